id_stage_pipe: RTL
==================

# id_stage_pipe

Parametrised decode stage with an integrated ID/EX pipeline register. It holds the general register file, selects forwarded operands, resolves branches and jumps in ID (one delay slot), computes the next PC, and registers the decoded operands, immediate, destination and link value for EX. Hold and bubble controls let the hazard unit stall the back end or inject NOPs.

## Interface
Parameters:
- DATA_W, 32, register/operand width; must be ≥ 32. PC is always 32 bits.
- REG_N, 32, number of GRF entries (power of two, ≥ 32). Address width is log2(REG_N), but instruction fields are 5 bits, so only regs 0..31 are architecturally addressable.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_pc  in  32  PC of instruction in IF
- id_pc  in  32  PC of instruction in ID
- id_instr  in  32  instruction in ID
- fwd_rs_sel / fwd_rt_sel  in  2 each  0 = GRF, 1 = fwd_mem_val, 2 = fwd_ex_val, 3 = GRF
- fwd_ex_val / fwd_mem_val  in  DATA_W each  forwarded results
- wb_we  in  1  GRF write enable
- wb_a3  in  5  GRF write address
- wb_wd  in  DATA_W  GRF write data
- wb_pc  in  32  PC of the writing instruction (display only)
- hold  in  1  keep ID/EX contents
- bubble  in  1  load a NOP into ID/EX
- npc  out  32  next PC (combinational)
- br_taken  out  1  branch/jump redirect (combinational)
- id_rs_use / id_rt_use  out  1 each  instruction in ID reads rs/rt (combinational)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_instr, ex_pc  out  32 each  registered instruction and PC
- ex_rs_val, ex_rt_val, ex_imm  out  DATA_W each  registered operands and extended immediate
- ex_a3  out  5  registered destination register, 0 = none
- ex_link  out  DATA_W  registered id_pc+8, zero-extended

## Operation
- GRF:
  - Write on a clock edge when wb_we=1 and wb_a3≠0.
  - Reg 0 always reads 0.
  - Reads are combinational with write-through: if wb_we=1 and wb_a3 equals a nonzero read address, the read returns wb_wd in the same cycle.
- Operand select: rs_f and rt_f come from the fwd_*_sel mux. rs_f/rt_f feed the comparator, jr, and ex_rs_val/ex_rt_val.
- Immediate extension:
  - Zero-extend for andi 001100, ori 001101, xori 001110.
  - lui 001111 gives imm<<16.
  - All other immediates are sign-extended to DATA_W.
- Branch conditions, compared as signed DATA_W values:
  - beq 000100: rs_f == rt_f
  - bne 000101: rs_f != rt_f
  - blez 000110: rs_f ≤ 0
  - bgtz 000111: rs_f > 0
  - REGIMM 000001: rt=00000 is bltz, rt=00001 is bgez
- Next PC:
  - Taken branch: id_pc+4+(sext(imm16)<<2).
  - j 000010 / jal 000011: {id_pc[31:28], imm26, 2'b00}.
  - jr (opcode 0, funct 001000): rs_f[31:0].
  - Otherwise: if_pc+4.
  - br_taken=1 for any redirect.
  - The delay-slot instruction is never squashed.
- Destination:
  - R-type: rd; jr gives 0.
  - ALU-immediate and loads: rt.
  - jal: 31.
  - Stores and branches: 0.
- id_rs_use=0 for j, jal, lui. id_rt_use=1 only for R-type, beq, bne and stores.

## Timing
- Combinational (same cycle): GRF read, npc, br_taken.
- ID/EX register latency: 1 cycle. Priority per edge:
  1. reset: all ex_* outputs = 0, ex_valid = 0; all GRF entries = 0.
  2. hold: all ex_* outputs unchanged. GRF writes still occur.
  3. bubble: ex_instr=0, ex_a3=0, ex_valid=0, other ex_* outputs = 0.
  4. else: load decoded values, ex_valid=1.
- hold and bubble together: hold wins.
- A reset mid-stall clears both states; the next cycle loads normally.

## Configuration
- GRF_DISPLAY_EN defined: every effective GRF write prints "@%h: $%d <= %h" (wb_pc, wb_a3, wb_wd) at the clock edge. Writes to reg 0 are suppressed and not printed.
- GRF_DISPLAY_EN undefined: no display statements are compiled in; functional behaviour is identical.

## Test plan
- Reset: reset=1 for 2 cycles → ex_valid=0, ex_a3=0; reading $5 gives 0.
- Write-through: wb_we=1, wb_a3=8, wb_wd=0x1234, while id_instr=addu $9,$8,$0 → ex_rs_val=0x1234 one cycle later. Write to $0 with 0xFFFF → $0 still reads 0.
- Branch: id_pc=0x3000, beq $1,$2,+3, fwd_rs_sel=2, fwd_ex_val=7, $2=7 → br_taken=1, npc=0x3010. Same with $2=6 → npc=if_pc+4.
- Jumps:
  - jal 0x0C01 at id_pc=0x3008 → npc=0x3004, ex_a3=31, ex_link=0x3010.
  - jr $31 with $31=0x3010 → npc=0x3010.
- Stall controls:
  - hold=1 for 3 cycles with changing id_instr → ex_* stable.
  - bubble=1 → ex_valid=0, ex_instr=0.
  - hold=bubble=1 → contents held.
- Signed compare and extension:
  - bltz with rs=0x80000000 → taken; bgez → not taken.
  - ori imm 0x8000 → ex_imm=0x00008000; addiu imm 0x8000 → 0xFFFF8000.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Decode stage with register file, operand forwarding, branch/jump resolution and ID/EX register.
// Define GRF_DISPLAY_EN to print every effective register-file write.
module id_stage_pipe #(
  parameter int DATA_W = 32,
  parameter int REG_N  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       id_pc,
  input  logic [31:0]       id_instr,
  input  logic [1:0]        fwd_rs_sel,
  input  logic [1:0]        fwd_rt_sel,
  input  logic [DATA_W-1:0] fwd_ex_val,
  input  logic [DATA_W-1:0] fwd_mem_val,
  input  logic              wb_we,
  input  logic [4:0]        wb_a3,
  input  logic [DATA_W-1:0] wb_wd,
  input  logic [31:0]       wb_pc,
  input  logic              hold,
  input  logic              bubble,
  output logic [31:0]       npc,
  output logic              br_taken,
  output logic              id_rs_use,
  output logic              id_rt_use,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_a3,
  output logic [DATA_W-1:0] ex_link
);
  localparam int AW = $clog2(REG_N);

  localparam logic [5:0] OP_R    = 6'b000000, OP_REGIMM = 6'b000001, OP_J   = 6'b000010,
                         OP_JAL  = 6'b000011, OP_BEQ    = 6'b000100, OP_BNE = 6'b000101,
                         OP_BLEZ = 6'b000110, OP_BGTZ   = 6'b000111, OP_ANDI = 6'b001100,
                         OP_ORI  = 6'b001101, OP_XORI   = 6'b001110, OP_LUI  = 6'b001111;
  localparam logic [5:0] FN_JR   = 6'b001000;

  logic [DATA_W-1:0] grf [REG_N];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  assign op    = id_instr[31:26];
  assign rs    = id_instr[25:21];
  assign rt    = id_instr[20:16];
  assign rd    = id_instr[15:11];
  assign funct = id_instr[5:0];
  assign imm16 = id_instr[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) grf[i] <= '0;
    end else if (wb_we && wb_a3 != 5'd0) begin
      grf[AW'(wb_a3)] <= wb_wd;
`ifdef GRF_DISPLAY_EN
      $display("@%h: $%d <= %h", wb_pc, wb_a3, wb_wd);
`endif
    end
  end

`ifndef GRF_DISPLAY_EN
  logic unused_wb_pc;
  assign unused_wb_pc = ^wb_pc;
`endif

  // Write-through lets the instruction in ID see a value being written back this cycle.
  logic [DATA_W-1:0] rs_g, rt_g, rs_f, rt_f;
  always_comb begin
    rs_g = '0;
    rt_g = '0;
    if (rs != 5'd0) rs_g = (wb_we && wb_a3 == rs) ? wb_wd : grf[AW'(rs)];
    if (rt != 5'd0) rt_g = (wb_we && wb_a3 == rt) ? wb_wd : grf[AW'(rt)];
    case (fwd_rs_sel)
      2'd1:    rs_f = fwd_mem_val;
      2'd2:    rs_f = fwd_ex_val;
      default: rs_f = rs_g;
    endcase
    case (fwd_rt_sel)
      2'd1:    rt_f = fwd_mem_val;
      2'd2:    rt_f = fwd_ex_val;
      default: rt_f = rt_g;
    endcase
  end

  logic is_jr, is_rtype, is_store, rs_neg, rs_zero, br_cond;
  assign is_rtype = (op == OP_R);
  assign is_jr    = is_rtype && funct == FN_JR;
  assign is_store = (op[5:3] == 3'b101);
  assign rs_neg   = rs_f[DATA_W-1];
  assign rs_zero  = (rs_f == '0);

  always_comb begin
    br_cond = 1'b0;
    case (op)
      OP_BEQ:    br_cond = (rs_f == rt_f);
      OP_BNE:    br_cond = (rs_f != rt_f);
      OP_BLEZ:   br_cond = rs_neg || rs_zero;
      OP_BGTZ:   br_cond = !rs_neg && !rs_zero;
      OP_REGIMM: br_cond = (rt == 5'd0) ? rs_neg : (rt == 5'd1) ? !rs_neg : 1'b0;
      default:   br_cond = 1'b0;
    endcase
  end

  always_comb begin
    npc      = if_pc + 32'd4;
    br_taken = 1'b1;
    if (br_cond)                        npc = id_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    else if (op == OP_J || op == OP_JAL) npc = {id_pc[31:28], id_instr[25:0], 2'b00};
    else if (is_jr)                     npc = rs_f[31:0];
    else                                br_taken = 1'b0;
  end

  logic [DATA_W-1:0] imm_ext;
  logic [4:0]        a3;
  always_comb begin
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: imm_ext = DATA_W'(imm16);
      OP_LUI:                   imm_ext = DATA_W'({imm16, 16'h0000});
      default:                  imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
    endcase
    // 001xxx are ALU-immediates, 100xxx are loads; both write rt.
    if (is_rtype)                               a3 = is_jr ? 5'd0 : rd;
    else if (op == OP_JAL)                      a3 = 5'd31;
    else if (op[5:3] == 3'b001 || op[5:3] == 3'b100) a3 = rt;
    else                                        a3 = 5'd0;
  end

  assign id_rs_use = !(op == OP_J || op == OP_JAL || op == OP_LUI);
  assign id_rt_use = is_rtype || op == OP_BEQ || op == OP_BNE || is_store;

  always_ff @(posedge clk) begin
    if (reset || (bubble && !hold)) begin
      ex_valid  <= 1'b0;
      ex_instr  <= '0;
      ex_pc     <= '0;
      ex_rs_val <= '0;
      ex_rt_val <= '0;
      ex_imm    <= '0;
      ex_a3     <= '0;
      ex_link   <= '0;
    end else if (!hold) begin
      ex_valid  <= 1'b1;
      ex_instr  <= id_instr;
      ex_pc     <= id_pc;
      ex_rs_val <= rs_f;
      ex_rt_val <= rt_f;
      ex_imm    <= imm_ext;
      ex_a3     <= a3;
      ex_link   <= DATA_W'(id_pc + 32'd8);
    end
  end
endmodule
